// File: rtl/bcd2bin_amisha_pkg.sv
// Shared constants, FSM state encoding and digit helpers for the BCD-to-binary converter.
package bcd2bin_pkg_amisha;

    localparam int DIGIT_W = 4;
    localparam int NUM_DIG = 4;
    localparam int BCD_W   = DIGIT_W * NUM_DIG;
    localparam int BIN_W   = 14;
    localparam int ITER    = 14;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OP   = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
        return d > DIGIT_W'(9);
    endfunction

endpackage

// File: rtl/bcd2bin_amisha_if.sv
// Start/result handshake bundle between decimal entry logic and the converter.
interface bcd2bin_if_amisha;
    import bcd2bin_pkg_amisha::*;

    logic               start_amisha;
    logic [DIGIT_W-1:0] bcd3_amisha;
    logic [DIGIT_W-1:0] bcd2_amisha;
    logic [DIGIT_W-1:0] bcd1_amisha;
    logic [DIGIT_W-1:0] bcd0_amisha;
    logic               ready_amisha;
    logic               done_tick_amisha;
    logic               err_amisha;
    logic [BIN_W-1:0]   bin_amisha;

    modport master (
        output start_amisha, bcd3_amisha, bcd2_amisha, bcd1_amisha, bcd0_amisha,
        input  ready_amisha, done_tick_amisha, err_amisha, bin_amisha
    );

    modport slave (
        input  start_amisha, bcd3_amisha, bcd2_amisha, bcd1_amisha, bcd0_amisha,
        output ready_amisha, done_tick_amisha, err_amisha, bin_amisha
    );

endinterface

// File: rtl/bcd2bin_amisha_corr.sv
// Reverse double-dabble digit fix-up: a digit that reached 8+ after the right shift loses 3.
module bcd_corr_amisha
    import bcd2bin_pkg_amisha::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] fixed
);

    assign fixed = (digit >= DIGIT_W'(8)) ? digit - DIGIT_W'(3) : digit;

endmodule

// File: rtl/bcd2bin_amisha.sv
// Iterative 4-digit BCD-to-binary converter: one right shift plus digit correction per cycle.
module bcd2bin_amisha
    import bcd2bin_pkg_amisha::*;
(
    input  logic             clk_amisha,
    input  logic             reset_amisha,
    bcd2bin_if_amisha.slave  bus
);

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   bcd_q, bcd_nxt;
    logic [BIN_W-1:0]   bin_q, bin_nxt;
    logic [CNT_W-1:0]   n_q, n_nxt;
    logic               err_q, err_nxt;

    logic [BCD_W+BIN_W-1:0]          shifted;
    logic [NUM_DIG-1:0][DIGIT_W-1:0] dig_sh, dig_fix;
    logic                            any_bad;

    // bcd0's LSB falls into the binary MSB as the 30-bit pair shifts right
    assign shifted = {bcd_q, bin_q} >> 1;
    assign dig_sh  = shifted[BCD_W+BIN_W-1:BIN_W];

    genvar g;
    generate
        for (g = 0; g < NUM_DIG; g++) begin : g_corr
            bcd_corr_amisha u_corr (
                .digit (dig_sh[g]),
                .fixed (dig_fix[g])
            );
        end
    endgenerate

    assign any_bad = digit_bad(bus.bcd3_amisha) | digit_bad(bus.bcd2_amisha) |
                     digit_bad(bus.bcd1_amisha) | digit_bad(bus.bcd0_amisha);

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            state <= ST_IDLE;
            bcd_q <= '0;
            bin_q <= '0;
            n_q   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            bcd_q <= bcd_nxt;
            bin_q <= bin_nxt;
            n_q   <= n_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bcd_nxt   = bcd_q;
        bin_nxt   = bin_q;
        n_nxt     = n_q;
        err_nxt   = err_q;
        case (state)
            ST_IDLE: begin
                if (bus.start_amisha) begin
                    bin_nxt = '0;
                    if (any_bad) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        bcd_nxt   = {bus.bcd3_amisha, bus.bcd2_amisha,
                                     bus.bcd1_amisha, bus.bcd0_amisha};
                        n_nxt     = CNT_W'(ITER);
                        err_nxt   = 1'b0;
                        state_nxt = ST_OP;
                    end
                end
            end
            ST_OP: begin
                bcd_nxt = dig_fix;
                bin_nxt = shifted[BIN_W-1:0];
                n_nxt   = n_q - CNT_W'(1);
                if (n_nxt == '0)
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.ready_amisha     = (state == ST_IDLE);
    assign bus.done_tick_amisha = (state == ST_DONE);
    assign bus.err_amisha       = err_q;
    assign bus.bin_amisha       = bin_q;

endmodule

// File: tb/tb_bcd2bin_amisha.sv
// Self-checking bench: vector table, hand-written handshake corner cases and random round-trips.
module tb_bcd2bin_amisha;

    logic clk_amisha = 1'b0;
    logic reset_amisha = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_amisha = ~clk_amisha;

    bcd2bin_if_amisha bus ();

    bcd2bin_amisha dut (
        .clk_amisha   (clk_amisha),
        .reset_amisha (reset_amisha),
        .bus          (bus.slave)
    );

    typedef struct {
        logic [3:0]  d3, d2, d1, d0;
        logic [13:0] exp_bin;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Decimal reading of the four digits; any non-decimal digit is an error with bin 0.
    task automatic ref_model(input logic [3:0] a, b, c, d,
                             output logic [13:0] rb, output logic re, output int lat);
        re  = (a > 9) || (b > 9) || (c > 9) || (d > 9);
        rb  = re ? 14'd0 : 14'(int'(a) * 1000 + int'(b) * 100 + int'(c) * 10 + int'(d));
        lat = re ? 1 : 15;
    endtask

    task automatic run_conv(input string tag, input logic [3:0] a, b, c, d,
                            input logic [13:0] eb, input logic ee, input int elat);
        int cnt;
        int rdy_seen;
        cnt = 0;
        rdy_seen = 0;
        @(negedge clk_amisha);
        bus.bcd3_amisha = a; bus.bcd2_amisha = b; bus.bcd1_amisha = c; bus.bcd0_amisha = d;
        bus.start_amisha = 1'b1;
        @(posedge clk_amisha);
        #1;
        bus.start_amisha = 1'b0;
        // scramble inputs after acceptance; result must not depend on them
        {bus.bcd3_amisha, bus.bcd2_amisha, bus.bcd1_amisha, bus.bcd0_amisha} = 16'($urandom);
        forever begin
            @(negedge clk_amisha);
            cnt++;
            if (bus.ready_amisha) rdy_seen++;
            if (bus.done_tick_amisha) break;
            if (cnt >= 40) begin
                chk({tag, " done timeout"}, 32'(cnt), 32'(elat));
                break;
            end
        end
        chk({tag, " latency"}, 32'(cnt), 32'(elat));
        chk({tag, " bin"}, 32'(bus.bin_amisha), 32'(eb));
        chk({tag, " err"}, 32'(bus.err_amisha), 32'(ee));
        chk({tag, " ready busy"}, 32'(rdy_seen), 32'd0);
        @(negedge clk_amisha);
        chk({tag, " ready after"}, {bus.ready_amisha, bus.done_tick_amisha}, 32'b10);
        chk({tag, " bin hold"}, 32'(bus.bin_amisha), 32'(eb));
    endtask

    initial begin
        logic [13:0] rb;
        logic        re;
        int          lat;
        int          cnt;
        int          t_done[$];
        logic [13:0] b_done[$];
        int          v;

        bus.start_amisha = 1'b0;
        {bus.bcd3_amisha, bus.bcd2_amisha, bus.bcd1_amisha, bus.bcd0_amisha} = '0;

        vecs.push_back('{4'd0, 4'd0, 4'd0, 4'd0, 14'd0,    1'b0, 15});
        vecs.push_back('{4'd9, 4'd9, 4'd9, 4'd9, 14'h270F, 1'b0, 15});
        vecs.push_back('{4'd1, 4'd2, 4'd3, 4'd4, 14'h04D2, 1'b0, 15});
        vecs.push_back('{4'd0, 4'd0, 4'd0, 4'd7, 14'd7,    1'b0, 15});
        vecs.push_back('{4'd8, 4'd1, 4'd9, 4'd1, 14'd8191, 1'b0, 15});
        vecs.push_back('{4'd1, 4'hA, 4'd0, 4'd0, 14'd0,    1'b1, 1});
        vecs.push_back('{4'd9, 4'd0, 4'd0, 4'd1, 14'd9001, 1'b0, 15});
        vecs.push_back('{4'd0, 4'd0, 4'd0, 4'hF, 14'd0,    1'b1, 1});
        vecs.push_back('{4'd5, 4'd0, 4'd8, 4'd0, 14'd5080, 1'b0, 15});

        repeat (3) @(negedge clk_amisha);
        chk("reset ready", 32'(bus.ready_amisha), 32'd1);
        chk("reset bin", 32'(bus.bin_amisha), 32'd0);
        chk("reset err", 32'(bus.err_amisha), 32'd0);
        chk("reset done", 32'(bus.done_tick_amisha), 32'd0);
        reset_amisha = 1'b0;

        foreach (vecs[i])
            run_conv($sformatf("vec%0d", i), vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0,
                     vecs[i].exp_bin, vecs[i].exp_err, vecs[i].exp_lat);

        // start pulse during op must not disturb the running conversion
        @(negedge clk_amisha);
        {bus.bcd3_amisha, bus.bcd2_amisha, bus.bcd1_amisha, bus.bcd0_amisha} = 16'h1234;
        bus.start_amisha = 1'b1;
        @(negedge clk_amisha);
        bus.start_amisha = 1'b0;
        cnt = 1;
        repeat (4) begin @(negedge clk_amisha); cnt++; end
        {bus.bcd3_amisha, bus.bcd2_amisha, bus.bcd1_amisha, bus.bcd0_amisha} = 16'h9999;
        bus.start_amisha = 1'b1;
        @(negedge clk_amisha);
        cnt++;
        bus.start_amisha = 1'b0;
        while (!bus.done_tick_amisha && cnt < 40) begin @(negedge clk_amisha); cnt++; end
        chk("midstart latency", 32'(cnt), 32'd15);
        chk("midstart bin", 32'(bus.bin_amisha), 32'd1234);
        @(negedge clk_amisha);
        chk("midstart ready", 32'(bus.ready_amisha), 32'd1);
        @(negedge clk_amisha);
        chk("midstart no restart", 32'(bus.ready_amisha), 32'd1);

        // asynchronous reset at T+7 aborts with no done_tick
        @(negedge clk_amisha);
        {bus.bcd3_amisha, bus.bcd2_amisha, bus.bcd1_amisha, bus.bcd0_amisha} = 16'h4321;
        bus.start_amisha = 1'b1;
        @(posedge clk_amisha);
        #1 bus.start_amisha = 1'b0;
        repeat (7) @(posedge clk_amisha);
        #2 reset_amisha = 1'b1;
        #1;
        chk("abort ready", 32'(bus.ready_amisha), 32'd1);
        chk("abort bin", 32'(bus.bin_amisha), 32'd0);
        chk("abort err", 32'(bus.err_amisha), 32'd0);
        @(negedge clk_amisha);
        reset_amisha = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk_amisha);
            if (bus.done_tick_amisha || !bus.ready_amisha) cnt++;
        end
        chk("abort quiet", 32'(cnt), 32'd0);
        run_conv("post-abort", 4'd2, 4'd0, 4'd2, 4'd5, 14'd2025, 1'b0, 15);

        // start held high: back-to-back conversions every 16 cycles
        @(negedge clk_amisha);
        {bus.bcd3_amisha, bus.bcd2_amisha, bus.bcd1_amisha, bus.bcd0_amisha} = 16'h0007;
        bus.start_amisha = 1'b1;
        cnt = 0;
        while (t_done.size() < 2 && cnt < 60) begin
            @(negedge clk_amisha);
            cnt++;
            if (bus.done_tick_amisha) begin
                t_done.push_back(cnt);
                b_done.push_back(bus.bin_amisha);
                if (t_done.size() == 2) bus.start_amisha = 1'b0;
            end
        end
        chk("held count", 32'(t_done.size()), 32'd2);
        if (t_done.size() == 2) begin
            chk("held first", 32'(t_done[0]), 32'd15);
            chk("held period", 32'(t_done[1] - t_done[0]), 32'd16);
            chk("held bin0", 32'(b_done[0]), 32'd7);
            chk("held bin1", 32'(b_done[1]), 32'd7);
        end
        repeat (20) @(negedge clk_amisha);

        // random round-trip over 0..8191, with occasional illegal digits
        for (int k = 0; k < 40; k++) begin
            logic [3:0] a, b, c, d;
            v = int'($urandom_range(0, 8191));
            a = 4'(v / 1000); b = 4'((v / 100) % 10); c = 4'((v / 10) % 10); d = 4'(v % 10);
            if ($urandom_range(0, 7) == 0) c = 4'($urandom_range(10, 15));
            ref_model(a, b, c, d, rb, re, lat);
            run_conv($sformatf("rnd%0d v=%0d", k, v), a, b, c, d, rb, re, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
